// File: rtl/first_conv.sv
// first_conv: 3x3 single-channel convolution over a raster 8-bit image stream.
// Loads nine signed weights and a bias, then streams pixels through two line
// buffers into a 3x3 window. A three-stage pipeline (multiply, sum, requantise)
// emits ReLU'd, shifted, saturated 8-bit features with their output coordinates.
module first_conv #(
  parameter int IMG_W = 34,
  parameter int IMG_H = 34,
  parameter int SHIFT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        coef_valid,
  input  logic [15:0] coef_data,
  input  logic        reload,
  input  logic        din_valid,
  input  logic [7:0]  din,
  output logic        din_ready,
  output logic        dout_valid,
  output logic [7:0]  dout,
  output logic [5:0]  out_col,
  output logic [5:0]  out_row,
  output logic        frame_done
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam logic [5:0] COL_LAST = 6'(IMG_W - 1);
  localparam logic [5:0] ROW_LAST = 6'(IMG_H - 1);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cidx_q, cidx_d;
  logic                      pend_q, pend_d;
  logic                      din_ready_q, din_ready_d;
  logic signed [COEF_W-1:0]  w_q[9], w_d[9];
  logic signed [15:0]        bias_q, bias_d;
  logic [5:0]                in_col_q, in_col_d, in_row_q, in_row_d;
  logic [DATA_W-1:0]         lb0_q[IMG_W], lb0_d[IMG_W];
  logic [DATA_W-1:0]         lb1_q[IMG_W], lb1_d[IMG_W];
  logic [DATA_W-1:0]         win_q[9], win_d[9];

  logic                      vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;
  logic [5:0]                col_p0_q, col_p0_d, row_p0_q, row_p0_d;
  logic signed [16:0]        prod_p1_q[9], prod_p1_d[9];
  logic                      vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic [5:0]                col_p1_q, col_p1_d, row_p1_q, row_p1_d;
  logic signed [20:0]        sum_p2_q, sum_p2_d;
  logic                      vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic [5:0]                col_p2_q, col_p2_d, row_p2_q, row_p2_d;
  logic                      dout_valid_q, dout_valid_d, frame_done_q, frame_done_d;
  logic [7:0]                dout_q, dout_d;
  logic [5:0]                out_col_q, out_col_d, out_row_q, out_row_d;

  logic accept;
  assign accept = din_valid && din_ready_q;

  // Unsigned pixel (zero-extended to 9 bits) times signed weight, 17-bit signed.
  function automatic logic signed [16:0] mul_px(input logic [DATA_W-1:0] px,
                                                input logic signed [COEF_W-1:0] w);
    logic signed [16:0] a, b;
    a = {9'b0, px};
    b = {{9{w[COEF_W-1]}}, w};
    return a * b;
  endfunction

  // ReLU, logical right shift, saturate to 8 bits.
  function automatic logic [7:0] requant(input logic signed [20:0] acc);
    logic [19:0] q;
    if (acc <= 21'sd0) return 8'd0;
    q = acc[19:0] >> SHIFT;
    return (q > 20'd255) ? 8'hFF : q[7:0];
  endfunction

  // Coefficient loading, reload handshake and input raster counters.
  always_comb begin
    state_d  = state_q;
    cidx_d   = cidx_q;
    pend_d   = pend_q;
    w_d      = w_q;
    bias_d   = bias_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    case (state_q)
      S_LOAD: begin
        if (coef_valid) begin
          if (cidx_q == 4'd9) begin
            bias_d  = coef_data;
            cidx_d  = 4'd0;
            state_d = S_RUN;
          end else begin
            w_d[cidx_q] = coef_data[COEF_W-1:0];
            cidx_d      = cidx_q + 4'd1;
          end
        end
      end
      default: begin
        if (reload) pend_d = 1'b1;
        if (accept) begin
          if (in_col_q == COL_LAST) begin
            in_col_d = 6'd0;
            in_row_d = (in_row_q == ROW_LAST) ? 6'd0 : in_row_q + 6'd1;
            if (in_row_q == ROW_LAST && pend_q) begin
              state_d = S_LOAD;
              pend_d  = 1'b0;
            end
          end else begin
            in_col_d = in_col_q + 6'd1;
          end
        end
      end
    endcase
    din_ready_d = (state_d == S_RUN);
  end

  // Window/line-buffer update and the multiply, sum, requantise pipeline.
  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    win_d = win_q;
    if (accept) begin
      win_d[0] = win_q[1];  win_d[1] = win_q[2];  win_d[2] = lb1_q[in_col_q];
      win_d[3] = win_q[4];  win_d[4] = win_q[5];  win_d[5] = lb0_q[in_col_q];
      win_d[6] = win_q[7];  win_d[7] = win_q[8];  win_d[8] = din;
      lb1_d[in_col_q] = lb0_q[in_col_q];
      lb0_d[in_col_q] = din;
    end
    // stage p0: tag the accepted beat
    vld_p0_d  = accept && (in_row_q >= 6'd2) && (in_col_q >= 6'd2);
    last_p0_d = accept && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
    col_p0_d  = in_col_q - 6'd2;
    row_p0_d  = in_row_q - 6'd2;
    // stage p1: nine products
    for (int i = 0; i < 9; i++) prod_p1_d[i] = mul_px(win_q[i], w_q[i]);
    vld_p1_d  = vld_p0_q;
    last_p1_d = last_p0_q;
    col_p1_d  = col_p0_q;
    row_p1_d  = row_p0_q;
    // stage p2: accumulate with bias
    sum_p2_d = {{5{bias_q[15]}}, bias_q};
    for (int i = 0; i < 9; i++) sum_p2_d = sum_p2_d + {{4{prod_p1_q[i][16]}}, prod_p1_q[i]};
    vld_p2_d  = vld_p1_q;
    last_p2_d = last_p1_q;
    col_p2_d  = col_p1_q;
    row_p2_d  = row_p1_q;
    // stage p3: registered outputs, held between valid strobes
    dout_valid_d = vld_p2_q;
    frame_done_d = vld_p2_q && last_p2_q;
    dout_d       = vld_p2_q ? requant(sum_p2_q) : dout_q;
    out_col_d    = vld_p2_q ? col_p2_q : out_col_q;
    out_row_d    = vld_p2_q ? row_p2_q : out_row_q;
  end

  // All state, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      cidx_q       <= '0;
      pend_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      bias_q       <= '0;
      in_col_q     <= '0;
      in_row_q     <= '0;
      for (int i = 0; i < 9; i++) begin
        w_q[i]       <= '0;
        win_q[i]     <= '0;
        prod_p1_q[i] <= '0;
      end
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      vld_p0_q <= 1'b0; last_p0_q <= 1'b0; col_p0_q <= '0; row_p0_q <= '0;
      vld_p1_q <= 1'b0; last_p1_q <= 1'b0; col_p1_q <= '0; row_p1_q <= '0;
      sum_p2_q <= '0;
      vld_p2_q <= 1'b0; last_p2_q <= 1'b0; col_p2_q <= '0; row_p2_q <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      dout_q       <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
    end else begin
      state_q      <= state_d;
      cidx_q       <= cidx_d;
      pend_q       <= pend_d;
      din_ready_q  <= din_ready_d;
      w_q          <= w_d;
      bias_q       <= bias_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      lb0_q        <= lb0_d;
      lb1_q        <= lb1_d;
      win_q        <= win_d;
      vld_p0_q <= vld_p0_d; last_p0_q <= last_p0_d; col_p0_q <= col_p0_d; row_p0_q <= row_p0_d;
      prod_p1_q    <= prod_p1_d;
      vld_p1_q <= vld_p1_d; last_p1_q <= last_p1_d; col_p1_q <= col_p1_d; row_p1_q <= row_p1_d;
      sum_p2_q     <= sum_p2_d;
      vld_p2_q <= vld_p2_d; last_p2_q <= last_p2_d; col_p2_q <= col_p2_d; row_p2_q <= row_p2_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      dout_q       <= dout_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_first_conv.sv
// Bench for first_conv: two instances (SHIFT=0 and SHIFT=7) share one input
// stream; a frame-level convolution model predicts every output, its
// coordinates and its cycle, and a constant-frame table checks hand-computed values.
module tb_first_conv;

  localparam int W = 34;
  localparam int H = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        coef_valid = 1'b0;
  logic [15:0] coef_data = '0;
  logic        reload = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  din = '0;

  logic       rdy0, dv0, fd0, rdy1, dv1, fd1;
  logic [7:0] d0, d1;
  logic [5:0] oc0, or0, oc1, or1;

  first_conv #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .coef_valid(coef_valid), .coef_data(coef_data),
    .reload(reload), .din_valid(din_valid), .din(din), .din_ready(rdy0),
    .dout_valid(dv0), .dout(d0), .out_col(oc0), .out_row(or0), .frame_done(fd0));

  first_conv #(.IMG_W(W), .IMG_H(H), .SHIFT(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .coef_valid(coef_valid), .coef_data(coef_data),
    .reload(reload), .din_valid(din_valid), .din(din), .din_ready(rdy1),
    .dout_valid(dv1), .dout(d1), .out_col(oc1), .out_row(or1), .frame_done(fd1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int img[H][W];
  int wm[9];
  int bm;

  typedef struct { int row; int col; int d0; int d7; int due; bit last; } exp_t;
  exp_t exp_q[$];

  function automatic int requant(int acc, int sh);
    int q;
    if (acc <= 0) return 0;
    q = acc >>> sh;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int conv(int r, int c);
    int acc = bm;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += img[r+i][c+j] * wm[i*3+j];
    return acc;
  endfunction

  // ---------------- output monitor ----------------
  int nvalid = 0, nfd = 0, last_d0 = 0, last_d7 = 0;
  always @(negedge clk) begin
    exp_t e;
    chk("valid_pair", int'(dv1), int'(dv0));
    if (dv0) begin
      nvalid++;
      if (fd0) nfd++;
      last_d0 = int'(d0);
      last_d7 = int'(d1);
      if (exp_q.size() == 0) begin
        chk("unexpected_dout_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_row", int'(or0), e.row);
        chk("out_col", int'(oc0), e.col);
        chk("dout_shift0", int'(d0), e.d0);
        chk("dout_shift7", int'(d1), e.d7);
        chk("latency_cycle", cyc, e.due);
        chk("frame_done", int'(fd0), int'(e.last));
        chk("out_col_s7", int'(oc1), e.col);
      end
    end else begin
      chk("frame_done_idle", int'(fd0), 0);
    end
  end

  // ---------------- stimulus tasks (all start/end at posedge+1) ----------------
  task automatic idle(input int n);
    din_valid = 1'b0;
    reload = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_coefs();
    int tmp;
    chk("load_ready_low", int'(rdy0), 0);
    for (int i = 0; i < 10; i++) begin
      coef_valid = 1'b1;
      if (i < 9) begin tmp = wm[i]; coef_data = {8'h00, tmp[7:0]}; end
      else begin tmp = bm; coef_data = tmp[15:0]; end
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    din_valid = 1'b0;
    chk("load_ready_high", int'(rdy0), 1);
    chk("load_ready_high_s7", int'(rdy1), 1);
  endtask

  task automatic make_img(input int kind, input int cval);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = cval;
          1: img[r][c] = (r * W + c) % 256;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic send_frame(input int gap_pct, input int reload_at, input int max_beats);
    int n = 0;
    bit rdy;
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n == max_beats) begin din_valid = 1'b0; reload = 1'b0; return; end
        for (int g = 0; g < 3; g++) begin
          if (int'($urandom_range(99)) >= gap_pct) break;
          din_valid = 1'b0; reload = 1'b0;
          @(posedge clk); #1;
        end
        din_valid = 1'b1;
        din = 8'(img[r][c]);
        reload = (n == reload_at);
        @(negedge clk);
        rdy = rdy0;
        @(posedge clk); #1;
        chk("din_ready_run", int'(rdy), 1);
        if (rdy && r >= 2 && c >= 2) begin
          e.row = r - 2;
          e.col = c - 2;
          e.d0 = requant(conv(r - 2, c - 2), 0);
          e.d7 = requant(conv(r - 2, c - 2), 7);
          e.due = cyc + 3;
          e.last = (r == H - 1) && (c == W - 1);
          exp_q.push_back(e);
        end
        n++;
      end
    end
    din_valid = 1'b0;
    reload = 1'b0;
  endtask

  task automatic drain();
    idle(6);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- table of constant-frame vectors ----------------
  typedef struct { int w; int b; int px; int e0; int e7; } vec_t;
  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f0;
    tbl[0]  = '{1,     0,  10,  90,   0};
    tbl[1]  = '{-1,    0, 200,   0,   0};
    tbl[2]  = '{127,   0, 255, 255, 255};
    tbl[3]  = '{1,   100,   0, 100,   0};
    tbl[4]  = '{2, -1000, 100, 255,   6};
    tbl[5]  = '{0,    -5,  77,   0,   0};
    tbl[6]  = '{1,    30,  25, 255,   1};
    tbl[7]  = '{1,    31,  25, 255,   2};
    tbl[8]  = '{-3, 2000,  50, 255,   5};
    tbl[9]  = '{1,   -90,  10,   0,   0};
    tbl[10] = '{1,   -89,  10,   1,   0};

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_din_ready", int'(rdy0), 0);
    chk("rst_dout_valid", int'(dv0), 0);
    chk("rst_dout", int'(d0), 0);
    chk("rst_out_col", int'(oc0), 0);
    chk("rst_out_row", int'(or0), 0);
    chk("rst_frame_done", int'(fd0), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // constant frames, reload mid-frame each time to move to the next vector
    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 9; i++) wm[i] = tbl[v].w;
      bm = tbl[v].b;
      load_coefs();
      make_img(0, tbl[v].px);
      n0 = nvalid;
      f0 = nfd;
      send_frame(0, W * H / 2, W * H);
      chk("ready_after_last", int'(rdy0), 0);
      drain();
      chk("pulse_count", nvalid - n0, (W - 2) * (H - 2));
      chk("frame_done_count", nfd - f0, 1);
      chk("tbl_dout_s0", last_d0, tbl[v].e0);
      chk("tbl_dout_s7", last_d7, tbl[v].e7);
    end

    // identity kernel on a ramp, bursty input
    for (int i = 0; i < 9; i++) wm[i] = 0;
    wm[4] = 1;
    bm = -5;
    load_coefs();
    make_img(1, 0);
    send_frame(50, 300, W * H);
    chk("ready_after_last_ramp", int'(rdy0), 0);
    drain();

    // random kernels: back-to-back frames, then the same frame with gaps
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 9; i++)
        wm[i] = (k == 0) ? int'($urandom_range(255)) - 128 : int'($urandom_range(20)) - 5;
      bm = int'($urandom_range(4000)) - 2000;
      load_coefs();
      make_img(2, 0);
      send_frame(0, -1, W * H);
      chk("ready_stays_high", int'(rdy0), 1);
      send_frame(50, 700, W * H);
      chk("ready_after_last_rand", int'(rdy0), 0);
      drain();
    end

    // asynchronous reset in the middle of a frame with outputs in flight
    for (int i = 0; i < 9; i++) wm[i] = 1;
    bm = 0;
    load_coefs();
    make_img(1, 0);
    send_frame(0, -1, 5 * W + 10);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_din_ready", int'(rdy0), 0);
    chk("midrst_dout_valid", int'(dv0), 0);
    chk("midrst_dout", int'(d0), 0);
    chk("midrst_out_col", int'(oc0), 0);
    chk("midrst_out_row", int'(or0), 0);
    chk("midrst_dout_s7", int'(d1), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    idle(3);
    chk("midrst_still_load", int'(rdy0), 0);
    for (int i = 0; i < 9; i++) wm[i] = 0;
    wm[4] = 1;
    bm = -5;
    load_coefs();
    make_img(1, 0);
    send_frame(30, 100, W * H);
    chk("ready_after_last_postrst", int'(rdy0), 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/first_conv.md
Name: first_conv

Overview:
- 3x3 single-channel convolution stage directly upstream of the first 2x2 max-pool stage in the CNN feature pipeline.
- Consumes a raster-order 8-bit unsigned image stream, IMG_W x IMG_H (default 34x34).
- Produces a (IMG_W-2) x (IMG_H-2) feature map (default 32x32) of 8-bit values: ReLU applied, right-shifted, saturated.
- Also emits output coordinates so the pooling controller can derive its calculation strobe.

Parameters:
- IMG_W, 34, input row length in pixels; range 3..64.
- IMG_H, 34, input rows per frame; range 3..64.
- SHIFT, 7, requantisation right-shift applied after ReLU; range 0..20.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- coef_valid  in  1  coefficient word strobe; sampled only in S_LOAD
- coef_data  in  16  indices 0..8: weight, signed, bits [7:0], row-major w00..w22; index 9: bias, signed 16-bit
- reload  in  1  one-cycle request to reload coefficients at the next frame boundary
- din_valid  in  1  pixel strobe; qualified by din_ready
- din  in  8  unsigned pixel
- din_ready  out  1  high only in S_RUN
- dout_valid  out  1  one-cycle strobe per output pixel
- dout  out  8  unsigned feature value
- out_col  out  6  output column of dout, 0..IMG_W-3
- out_row  out  6  output row of dout, 0..IMG_H-3
- frame_done  out  1  pulses with dout_valid for the last output pixel of a frame

Behaviour:
- Reset values:
  - FSM = S_LOAD; coefficient index = 0.
  - All weights, bias, line buffers, window, counters and pipeline registers = 0.
  - din_ready = 0, dout_valid = 0, dout = 0, out_col = 0, out_row = 0, frame_done = 0.
- FSM S_LOAD:
  - Each cycle with coef_valid=1 stores coef_data at the current index, then increments the index.
  - The store at index 9 sets index to 0 and moves the FSM to S_RUN.
  - din is ignored.
- FSM S_RUN:
  - din_ready = 1. An input beat is accepted on any edge with din_valid && din_ready.
  - coef_valid is ignored.
  - If reload is seen, a pending flag is set.
  - When the pending flag is set and the last pixel of a frame is accepted, the FSM goes to S_LOAD on that same edge. din_ready falls the next cycle.
  - Pipeline contents continue to drain after the transition.
- Input counters:
  - in_col increments per accepted beat and wraps at IMG_W-1 to 0, incrementing in_row.
  - in_row wraps at IMG_H-1 to 0. There is no other frame-sync input.
- Buffering:
  - Two line buffers of IMG_W bytes hold the previous two rows.
  - The 3x3 window shifts by one column per accepted beat. Rows are read from line buffer 1, line buffer 0 and din.
  - No state changes on cycles without an accepted beat. Bubbles are allowed at any position, including across row and frame boundaries.
- Window valid: the accepted beat is tagged valid when in_row>=2 and in_col>=2 (pre-increment values). Tagged output coordinates are (in_row-2, in_col-2).
- Pipeline, free-running; valid bits advance every clock:
  - Edge E (accept): window updated.
  - E+1: nine products registered, pixel zero-extended to 9 bits x signed weight, 17-bit signed.
  - E+2: 21-bit signed sum of the nine products plus the sign-extended bias.
  - E+3: dout, dout_valid, out_col, out_row, frame_done registered.
  - Latency is exactly 3 clocks from the accepting edge, independent of later stalls.
- Requantisation:
  - acc <= 0 gives 0.
  - Otherwise q = acc >> SHIFT (logical); dout = q > 255 ? 255 : q[7:0].
- When dout_valid=0, dout, out_col and out_row hold their last values and frame_done = 0.
- The first two rows and the first two columns of every row produce no output. Output row length is IMG_W-2.
- Coefficients change only in S_LOAD. An in-flight pipeline uses whatever weights are in the registers when each stage computes. The bench must drain the pipeline before the reload completes.
- Asynchronous reset mid-frame:
  - Everything returns to the reset values, including weights.
  - The first beats after reset are treated as coefficients.

Test Plan:
- Reset, load weights all 1, bias 0, SHIFT=0; stream a 34x34 frame of constant 10 -> exactly 1024 dout_valid pulses, each dout=90. out_col/out_row sweep 0..31 in raster order. frame_done only on (31,31). First dout_valid 3 clocks after input beat (2,2).
- Weights all -1, bias 0, constant 200 -> all dout=0. Weights all 127, bias 0, SHIFT=7, constant 255 -> acc=291465, q=2277, dout=255.
- Identity kernel (w11=1, others 0), SHIFT=0, bias=-5, ramp pixel=(row*34+col)%256 -> dout = max(0, pixel at input (r+1,c+1) - 5).
- Random din_valid gaps (about 50% duty), including gaps at row and frame ends -> identical dout sequence to the gap-free run. Each result exactly 3 clocks after its accepting beat.
- reload pulsed mid-frame -> din_ready drops after the frame's last accepted beat. Remaining outputs drain. Ten new coefficients load. The second frame uses the new weights.
- rst_n asserted mid-frame and mid-pipeline -> outputs and din_ready go to 0 immediately. After release, the block is in S_LOAD with coefficient index 0.
